// File: rtl/hazard_dedup_gate_if.sv
// Ingress/egress/snoop signal bundle for hazard_dedup_gate.
// master = gate side, slave = upstream source + FIFO side.
interface hazard_dedup_gate_if #(
    parameter int DATA_W = 140
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] snp_data;
    logic              snp_valid;
    logic              snp_match;

    modport master (
        input  in_data, in_valid, out_ready, snp_match,
        output in_ready, out_data, out_valid, snp_data, snp_valid
    );

    modport slave (
        output in_data, in_valid, out_ready, snp_match,
        input  in_ready, out_data, out_valid, snp_data, snp_valid
    );
endinterface

// File: rtl/hazard_dedup_gate.sv
// Ingress gate in front of a snoopable FIFO: hold word, snoop for a pending twin, then forward or drop.
// Optional macro HAZARD_DEDUP_GATE_DROP_EN: matched words are dropped instead of only counted.
module hazard_dedup_gate #(
    parameter int DATA_W    = 140,
    parameter int DUP_CNT_W = 16,
    parameter int STALL_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    hazard_dedup_gate_if.master  bus,
    output logic                 dup_pulse,
    output logic [DUP_CNT_W-1:0] dup_cnt,
    output logic                 stall_err,
    input  logic                 err_clr
);
    localparam int CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);

    typedef enum logic [1:0] {IDLE, SNOOP, SEND} state_e;

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic                 stall_err_q, stall_err_d;
    logic [DUP_CNT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic                 dup_hit, stalled;

    assign dup_hit = (state_q == SNOOP) && bus.snp_match;
    assign stalled = (state_q == SEND) && !bus.out_ready;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == SEND) && bus.out_ready);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = hold_q;
    assign bus.snp_valid = (state_q == SNOOP);
    assign bus.snp_data  = hold_q;
    assign dup_cnt       = dup_cnt_q;
    assign stall_err     = stall_err_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    state_d = SNOOP;
                end
            end
            SNOOP: begin
`ifdef HAZARD_DEDUP_GATE_DROP_EN
                state_d = dup_hit ? IDLE : SEND;
`else
                state_d = SEND;
`endif
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        hold_d  = bus.in_data;
                        state_d = SNOOP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog keeps re-asserting while still stuck at the limit, so a clear mid-stall is not lost.
    always_comb begin
        stall_d = '0;
        if (stalled)
            stall_d = (stall_q == STALL_LIM) ? stall_q : stall_q + 1'b1;
        stall_err_d = stall_err_q || (stalled && (stall_d == STALL_LIM));
        if (err_clr)
            stall_err_d = 1'b0;
    end

    always_comb begin
        dup_cnt_d = dup_cnt_q;
        if (err_clr)
            dup_cnt_d = '0;
        else if (dup_hit && !(&dup_cnt_q))
            dup_cnt_d = dup_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            stall_q     <= '0;
            stall_err_q <= 1'b0;
            dup_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_q     <= stall_d;
            stall_err_q <= stall_err_d;
            dup_cnt_q   <= dup_cnt_d;
        end
    end

`ifdef HAZARD_DEDUP_GATE_DROP_EN
    logic dup_pulse_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dup_pulse_q <= 1'b0;
        else       dup_pulse_q <= dup_hit;
    end
    assign dup_pulse = dup_pulse_q;
`else
    // Statistics-only mode flags the match in the snoop cycle itself.
    assign dup_pulse = dup_hit;
`endif
endmodule

// File: tb/tb_hazard_dedup_gate.sv
// Self-checking bench for hazard_dedup_gate: directed plan steps plus a randomized scoreboard phase.
module tb_hazard_dedup_gate;
    localparam int DW      = 140;
    localparam int CW      = 4;
    localparam int SMAX    = 255;
    localparam int CNT_SAT = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dup_pulse;
    logic [CW-1:0] dup_cnt;
    logic          stall_err;
    logic          err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] out_q[$];
    int            dup_exp = 0;
    bit            prev_hit = 1'b0;

    hazard_dedup_gate_if #(.DATA_W(DW)) bif ();

    hazard_dedup_gate #(.DATA_W(DW), .DUP_CNT_W(CW), .STALL_MAX(SMAX)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bif.master),
        .dup_pulse (dup_pulse),
        .dup_cnt   (dup_cnt),
        .stall_err (stall_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // One isolated word through IDLE->SNOOP->(SEND)->IDLE with out_ready=1.
    task automatic send_word(input logic [DW-1:0] d, input bit m, input int exp_cnt);
        nxt(); bif.in_data = d; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        smp();
        nxt(); bif.in_valid = 1'b0; bif.snp_match = m;
        smp();
        chk("sw_snp_valid", bif.snp_valid, 1);
`ifdef HAZARD_DEDUP_GATE_DROP_EN
        chk("sw_pulse_snoop", dup_pulse, 0);
`else
        chk("sw_pulse_snoop", dup_pulse, m);
`endif
        nxt(); bif.snp_match = 1'b0;
        smp();
`ifdef HAZARD_DEDUP_GATE_DROP_EN
        chk("sw_pulse_after", dup_pulse, m);
        chk("sw_out_valid", bif.out_valid, !m);
        if (!m) chk("sw_out_data", bif.out_data, d);
`else
        chk("sw_pulse_after", dup_pulse, 0);
        chk("sw_out_valid", bif.out_valid, 1);
        chk("sw_out_data", bif.out_data, d);
`endif
        chk("sw_dup_cnt", dup_cnt, exp_cnt);
        nxt();
        smp();
        chk("sw_idle_out_valid", bif.out_valid, 0);
        chk("sw_idle_in_ready", bif.in_ready, 1);
    endtask

    // Scoreboard monitor, called at the sampling point of each cycle.
    task automatic mon(output bit out_hs);
        bit hit;
        hit = bif.snp_valid && bif.snp_match;
        if (bif.snp_valid) begin
            chk("snp_q_nonempty", acc_q.size() > 0, 1);
            if (acc_q.size() > 0) begin
                logic [DW-1:0] w;
                w = acc_q.pop_front();
                chk("snp_data", bif.snp_data, w);
                if (hit && dup_exp < CNT_SAT) dup_exp++;
`ifdef HAZARD_DEDUP_GATE_DROP_EN
                if (!hit) out_q.push_back(w);
`else
                out_q.push_back(w);
`endif
            end
        end
`ifdef HAZARD_DEDUP_GATE_DROP_EN
        chk("dup_pulse", dup_pulse, prev_hit);
`else
        chk("dup_pulse", dup_pulse, hit);
`endif
        prev_hit = hit;
        out_hs = bif.out_valid && bif.out_ready;
        if (out_hs) begin
            chk("out_q_nonempty", out_q.size() > 0, 1);
            if (out_q.size() > 0) chk("out_data", bif.out_data, out_q.pop_front());
        end
        if (bif.in_valid && bif.in_ready) acc_q.push_back(bif.in_data);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] w8[8];
        bit hs;
        int idx, nout, last_t;

        rstn = 1'b0; err_clr = 1'b0;
        bif.in_data = '0; bif.in_valid = 1'b0; bif.out_ready = 1'b0; bif.snp_match = 1'b0;
        #12;
        chk("rst_in_ready", bif.in_ready, 1);
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_snp_valid", bif.snp_valid, 0);
        chk("rst_dup_pulse", dup_pulse, 0);
        chk("rst_dup_cnt", dup_cnt, 0);
        chk("rst_stall_err", stall_err, 0);
        chk("rst_snp_data", bif.snp_data, 0);
        @(negedge clk); rstn = 1'b1;

        // Basic latency: accept at N, snoop at N+1, out at N+2, idle at N+3.
        nxt(); bif.in_data = DW'(8'h5A); bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        smp(); chk("lat_c0_in_ready", bif.in_ready, 1);
        nxt(); bif.in_valid = 1'b0;
        smp();
        chk("lat_c1_snp_valid", bif.snp_valid, 1);
        chk("lat_c1_snp_data", bif.snp_data, DW'(8'h5A));
        chk("lat_c1_in_ready", bif.in_ready, 0);
        chk("lat_c1_out_valid", bif.out_valid, 0);
        nxt(); smp();
        chk("lat_c2_out_valid", bif.out_valid, 1);
        chk("lat_c2_out_data", bif.out_data, DW'(8'h5A));
        chk("lat_c2_snp_valid", bif.snp_valid, 0);
        nxt(); smp();
        chk("lat_c3_out_valid", bif.out_valid, 0);
        chk("lat_c3_in_ready", bif.in_ready, 1);

        // Watchdog: hold out_ready low for 300 cycles.
        d = rnd_word();
        nxt(); bif.in_data = d; bif.in_valid = 1'b1; bif.out_ready = 1'b0;
        smp();
        nxt(); bif.in_valid = 1'b0; bif.in_data = '0;
        smp();
        for (int k = 0; k < 300; k++) begin
            nxt(); smp();
            chk("stall_out_valid", bif.out_valid, 1);
            chk("stall_out_data", bif.out_data, d);
            chk("stall_in_ready", bif.in_ready, 0);
            chk("stall_err_k", stall_err, (k >= SMAX));
        end
        nxt(); bif.out_ready = 1'b1;
        smp(); chk("stall_release_in_ready", bif.in_ready, 1);
        nxt(); smp();
        chk("stall_done_out_valid", bif.out_valid, 0);
        chk("stall_err_sticky", stall_err, 1);
        nxt(); err_clr = 1'b1;
        smp();
        nxt(); err_clr = 1'b0;
        smp(); chk("stall_err_cleared", stall_err, 0);

        // Single duplicate, then saturation of the 4-bit counter.
        send_word(rnd_word(), 1'b1, 1);
        send_word(rnd_word(), 1'b0, 1);
        for (int i = 0; i < 16; i++)
            send_word(rnd_word(), 1'b1, (i + 2 > CNT_SAT) ? CNT_SAT : i + 2);
        nxt(); err_clr = 1'b1;
        smp();
        nxt(); err_clr = 1'b0;
        smp(); chk("dup_cnt_cleared", dup_cnt, 0);

        // Stream of 8 words through the back-to-back path.
        for (int i = 0; i < 8; i++) w8[i] = rnd_word();
        idx = 0; nout = 0; last_t = 0;
        for (int t = 0; t < 40 && nout < 8; t++) begin
            nxt();
            bif.in_valid = (idx < 8); bif.in_data = (idx < 8) ? w8[idx] : '0;
            bif.out_ready = 1'b1; bif.snp_match = 1'b0;
            smp();
            if (bif.in_valid && bif.in_ready) idx++;
            mon(hs);
            if (hs) begin
                if (nout > 0) chk("stream_gap", t - last_t, 2);
                last_t = t; nout++;
            end
        end
        chk("stream_count", nout, 8);
        bif.in_valid = 1'b0;

        // Async reset while a word sits in SEND.
        nxt(); bif.in_data = rnd_word(); bif.in_valid = 1'b1; bif.out_ready = 1'b0;
        smp();
        nxt(); bif.in_valid = 1'b0;
        smp();
        nxt(); smp();
        chk("pre_rst_out_valid", bif.out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_out_valid", bif.out_valid, 0);
        chk("async_rst_in_ready", bif.in_ready, 1);
        chk("async_rst_snp_data", bif.snp_data, 0);
        @(negedge clk); rstn = 1'b1; bif.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            nxt(); smp();
            chk("post_rst_no_emit", bif.out_valid, 0);
        end

        // Randomized phase against the scoreboard.
        acc_q.delete(); out_q.delete(); dup_exp = 0; prev_hit = 1'b0;
        for (int t = 0; t < 600; t++) begin
            nxt();
            bif.in_valid  = $urandom_range(0, 1) == 1;
            bif.in_data   = rnd_word();
            bif.out_ready = $urandom_range(0, 3) != 0;
            bif.snp_match = $urandom_range(0, 2) == 0;
            smp();
            mon(hs);
        end
        for (int t = 0; t < 20; t++) begin
            nxt();
            bif.in_valid = 1'b0; bif.out_ready = 1'b1; bif.snp_match = 1'b0;
            smp();
            mon(hs);
        end
        chk("rand_acc_drained", acc_q.size(), 0);
        chk("rand_out_drained", out_q.size(), 0);
        chk("rand_dup_cnt", dup_cnt, dup_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_dedup_gate.md
Name: hazard_dedup_gate

Overview:
- Ingress stage placed directly upstream of the snoopable FIFO.
- Registers each incoming word, snoops the FIFO for an identical pending entry, and then either forwards the word into the FIFO write port or suppresses it as a duplicate.
- Provides duplicate statistics and a sticky back-pressure watchdog.

Parameters:
- DATA_W, 140, width of the data word; equals the FIFO word width.
- DUP_CNT_W, 16, width of the saturating duplicate counter.
- STALL_MAX, 255, number of consecutive cycles with out_valid=1 and out_ready=0 before stall_err is set; range 1..65535.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- in_data  in  DATA_W  upstream word.
- in_valid  in  1  upstream valid.
- in_ready  out  1  gate can accept.
- out_data  out  DATA_W  to FIFO wdata.
- out_valid  out  1  to FIFO wvalid.
- out_ready  in  1  from FIFO wready.
- snp_data  out  DATA_W  to FIFO sdata.
- snp_valid  out  1  to FIFO svalid.
- snp_match  in  1  from FIFO smatch; combinational response to snp_data/snp_valid in the same cycle.
- dup_pulse  out  1  one-cycle pulse when a duplicate is detected.
- dup_cnt  out  DUP_CNT_W  saturating count of duplicates.
- stall_err  out  1  sticky watchdog flag.
- err_clr  in  1  synchronous clear for stall_err and dup_cnt.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State returns to IDLE; hold register cleared to 0.
  - in_ready=1, out_valid=0, snp_valid=0, dup_pulse=0, dup_cnt=0, stall_err=0, stall counter=0.
  - Reset mid-transfer discards the held word silently.
- FSM states: IDLE, SNOOP, SEND.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data into hold; next state SNOOP.
- SNOOP (exactly 1 cycle):
  - snp_valid=1, snp_data=hold, in_ready=0, out_valid=0.
  - snp_match is sampled at the closing edge.
  - Match and drop active (see Optional Feature): dup_pulse=1 next cycle, dup_cnt+1 (saturates at all-ones), next state IDLE.
  - Otherwise: next state SEND.
- SEND:
  - out_valid=1, out_data=hold; hold is stable until the handshake completes.
  - On out_ready=1 the word is written to the FIFO.
  - If in_valid is also high in that cycle: capture the new word, next state SNOOP (back-to-back path).
  - If in_valid is low: next state IDLE.
- in_ready = (state==IDLE) | (state==SEND & out_ready); purely combinational from state and out_ready.
- Latency: word accepted at cycle N → snoop at N+1 → out_valid at N+2. Sustained throughput is 1 word per 2 cycles.
- snp_valid is 0 in every state except SNOOP; snp_data = hold at all times.
- Stall watchdog:
  - Counter increments each SEND cycle with out_ready=0; cleared on handshake or on leaving SEND.
  - When the counter reaches STALL_MAX, stall_err=1 (sticky) and the counter holds.
  - The gate keeps waiting; the word is never dropped on timeout.
- err_clr=1: stall_err and dup_cnt go to 0 next cycle.
  - If err_clr coincides with a duplicate event, clear wins: dup_cnt=0, but dup_pulse still fires.
- FIFO full: out_ready=0 holds SEND indefinitely; upstream is back-pressured via in_ready=0.
- Staleness: snoop result is valid for the snoop cycle only. Entries drained from the FIFO between SNOOP and SEND are not re-checked (decided).
- snp_match is ignored outside SNOOP.

Optional Feature:
- Macro: HAZARD_DEDUP_GATE_DROP_EN.
- Defined: a matched word is dropped; FSM goes SNOOP→IDLE, no out_valid, dup_pulse and dup_cnt update.
- Undefined:
  - A matched word is still forwarded (SNOOP→SEND).
  - dup_pulse is asserted during the SNOOP cycle itself, and dup_cnt increments; statistics only, nothing is dropped.

Test Plan:
- Reset, then in_data=0x5A with in_valid=1 at cycle 0, snp_match=0, out_ready=1 → snp_valid=1 with snp_data=0x5A at cycle 1; out_valid=1 with out_data=0x5A at cycle 2; back to IDLE at cycle 3.
- DROP_EN defined, snp_match=1 during SNOOP → out_valid stays 0, dup_pulse=1 for one cycle, dup_cnt=1. DROP_EN undefined → word forwarded at cycle 2 and dup_cnt=1.
- Hold out_ready=0 for 300 cycles with STALL_MAX=255 → stall_err rises after 255 stall cycles; out_data stable; out_ready=1 completes the transfer; err_clr clears the flag.
- Stream 8 words with in_valid=1, out_ready=1, snp_match=0 → all 8 appear in order, one every 2 cycles, via the SEND→SNOOP back-to-back path.
- Assert rstn=0 while in SEND with out_valid=1 → out_valid=0 immediately (asynchronous); after release the old word is never emitted.
- Set dup_cnt to all-ones (DUP_CNT_W=4, 16 matches) → dup_cnt stays at 15, dup_pulse still fires on each match.
